// File: rtl/fibonacci_core_if.sv
// Control and result bundle between the Wishbone control block and the Fibonacci core.
// The master drives run/rate/restart; the slave (core) returns the current term and status pulses.
interface fibonacci_core_if #(
    parameter int unsigned CLOCK_WIDTH = 6,
    parameter int unsigned WIDTH       = 30,
    parameter int unsigned IDX_WIDTH   = 6
);
    logic                   switch;
    logic [CLOCK_WIDTH-1:0] clock_sel;
    logic                   restart;
    logic [WIDTH-1:0]       io_out;
    logic [WIDTH-1:0]       io_oeb;
    logic [IDX_WIDTH-1:0]   index;
    logic                   tick_o;
    logic                   wrap_o;

    modport master (
        output switch, clock_sel, restart,
        input  io_out, io_oeb, index, tick_o, wrap_o
    );

    modport slave (
        input  switch, clock_sel, restart,
        output io_out, io_oeb, index, tick_o, wrap_o
    );
endinterface

// File: rtl/fibonacci_core.sv
// Fibonacci term generator stepping at a programmable divided rate; wraps to F(0) once the
// next term no longer fits in WIDTH bits.
module fibonacci_core #(
    parameter int unsigned CLOCK_WIDTH = 6,
    parameter int unsigned WIDTH       = 30,
    parameter int unsigned IDX_WIDTH   = 6
) (
    input  logic              wb_clk_i,
    input  logic              reset_n,
    fibonacci_core_if.slave   bus
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [CLOCK_WIDTH-1:0] ClkOne = CLOCK_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0]   IdxOne = IDX_WIDTH'(1);
    localparam logic [WIDTH-1:0]       TermOne = WIDTH'(1);

    state_e                 r_state, w_state_nxt;
    logic [WIDTH-1:0]       r_a, w_a_nxt;
    logic [WIDTH-1:0]       r_b, w_b_nxt;
    logic                   r_b_ovf, w_b_ovf_nxt;
    logic [CLOCK_WIDTH-1:0] r_div_cnt, w_div_cnt_nxt;
    logic [IDX_WIDTH-1:0]   r_index, w_index_nxt;
    logic                   r_tick, w_tick_nxt;
    logic                   r_wrap, w_wrap_nxt;
    logic                   r_oeb;
    logic                   w_step;
    logic [WIDTH:0]         w_sum;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b};

    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= StIdle;
            r_a       <= '0;
            r_b       <= TermOne;
            r_b_ovf   <= 1'b0;
            r_div_cnt <= '0;
            r_index   <= '0;
            r_tick    <= 1'b0;
            r_wrap    <= 1'b0;
            r_oeb     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_b_ovf   <= w_b_ovf_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_index   <= w_index_nxt;
            r_tick    <= w_tick_nxt;
            r_wrap    <= w_wrap_nxt;
            r_oeb     <= 1'b0;
        end
    end

    always_comb begin
        w_state_nxt   = bus.switch ? StRun : StIdle;
        w_a_nxt       = r_a;
        w_b_nxt       = r_b;
        w_b_ovf_nxt   = r_b_ovf;
        w_div_cnt_nxt = r_div_cnt;
        w_index_nxt   = r_index;
        w_tick_nxt    = 1'b0;
        w_wrap_nxt    = 1'b0;
        w_step        = 1'b0;

        if (bus.restart) begin
            w_a_nxt       = '0;
            w_b_nxt       = TermOne;
            w_b_ovf_nxt   = 1'b0;
            w_index_nxt   = '0;
            w_div_cnt_nxt = '0;
        end else begin
            unique case (r_state)
                StIdle: w_div_cnt_nxt = '0;
                StRun: begin
                    // A falling switch suppresses a step that would otherwise be due now.
                    if (!bus.switch || bus.clock_sel == '0) begin
                        w_div_cnt_nxt = '0;
                    end else if (r_div_cnt >= bus.clock_sel - ClkOne) begin
                        w_div_cnt_nxt = '0;
                        w_step        = 1'b1;
                    end else begin
                        w_div_cnt_nxt = r_div_cnt + ClkOne;
                    end
                end
                default: w_div_cnt_nxt = '0;
            endcase

            if (w_step) begin
                w_tick_nxt = 1'b1;
                if (r_b_ovf) begin
                    w_a_nxt     = '0;
                    w_b_nxt     = TermOne;
                    w_b_ovf_nxt = 1'b0;
                    w_index_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_a_nxt                  = r_b;
                    {w_b_ovf_nxt, w_b_nxt}   = w_sum;
                    w_index_nxt              = r_index + IdxOne;
                end
            end
        end
    end

    assign bus.io_out = r_a;
    assign bus.io_oeb = {WIDTH{r_oeb}};
    assign bus.index  = r_index;
    assign bus.tick_o = r_tick;
    assign bus.wrap_o = r_wrap;

endmodule

// File: tb/tb_fibonacci_core.sv
// Bench for fibonacci_core: directed scenarios with literal expectations, then random run/rate/
// restart stimulus, all compared every cycle against an index-based Fibonacci model.
module tb_fibonacci_core;

    localparam int unsigned CW = 6;
    localparam int unsigned W  = 30;
    localparam int unsigned IW = 6;

    logic clk;
    logic rst_n;

    fibonacci_core_if #(.CLOCK_WIDTH(CW), .WIDTH(W), .IDX_WIDTH(IW)) bus_if ();

    fibonacci_core #(.CLOCK_WIDTH(CW), .WIDTH(W), .IDX_WIDTH(IW)) dut (
        .wb_clk_i (clk),
        .reset_n  (rst_n),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: the term index, cycles spent towards the next step, and run status.
    int m_n;
    int m_cnt;
    bit m_run;
    bit m_tick;
    bit m_wrap;
    bit m_oeb;

    bit     lit_en = 1'b0;
    longint lit_out;
    int     lit_idx;
    bit     lit_tick;
    bit     lit_wrap;
    bit     lit_oeb;

    function automatic longint fib_of(input int n);
        longint x = 0;
        longint y = 1;
        longint t;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Highest n whose F(n) still fits in W bits; the step after it wraps.
    function automatic int last_index();
        longint lim = 64'd1 << W;
        int n = 0;
        while (fib_of(n + 1) < lim) n++;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run  <= 1'b0;
            m_cnt  <= 0;
            m_n    <= 0;
            m_tick <= 1'b0;
            m_wrap <= 1'b0;
            m_oeb  <= 1'b1;
        end else begin
            m_tick <= 1'b0;
            m_wrap <= 1'b0;
            m_oeb  <= 1'b0;
            m_run  <= bus_if.switch;
            if (bus_if.restart) begin
                m_n   <= 0;
                m_cnt <= 0;
            end else if (m_run && bus_if.switch && bus_if.clock_sel != 0) begin
                if (m_cnt + 1 >= int'(bus_if.clock_sel)) begin
                    m_cnt  <= 0;
                    m_tick <= 1'b1;
                    m_wrap <= (m_n == last_index());
                    m_n    <= (m_n == last_index()) ? 0 : m_n + 1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_cnt <= 0;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("io_out", longint'(bus_if.io_out), fib_of(m_n));
        check("index", longint'(bus_if.index), longint'(m_n));
        check("tick_o", longint'(bus_if.tick_o), longint'(m_tick));
        check("wrap_o", longint'(bus_if.wrap_o), longint'(m_wrap));
        check("io_oeb", longint'(bus_if.io_oeb), m_oeb ? (64'd1 << W) - 1 : 64'd0);
        if (lit_en) begin
            check("lit_io_out", longint'(bus_if.io_out), lit_out);
            check("lit_index", longint'(bus_if.index), longint'(lit_idx));
            check("lit_tick_o", longint'(bus_if.tick_o), longint'(lit_tick));
            check("lit_wrap_o", longint'(bus_if.wrap_o), longint'(lit_wrap));
            check("lit_io_oeb", longint'(bus_if.io_oeb), lit_oeb ? (64'd1 << W) - 1 : 64'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
        lit_en = 1'b0;
    endtask

    task automatic expect_lit(input longint out, input int idx, input bit tick, input bit wrap,
                              input bit oeb);
        lit_out  = out;
        lit_idx  = idx;
        lit_tick = tick;
        lit_wrap = wrap;
        lit_oeb  = oeb;
        lit_en   = 1'b1;
    endtask

    initial begin
        int seq[7] = '{0, 1, 1, 2, 3, 5, 8};
        int r;

        rst_n = 1'b0;
        bus_if.switch    = 1'b1;
        bus_if.clock_sel = CW'(1);
        bus_if.restart   = 1'b0;
        expect_lit(0, 0, 1'b0, 1'b0, 1'b1);
        cyc();
        cyc();
        rst_n = 1'b1;

        // Every-cycle stepping straight out of reset.
        for (int i = 0; i < 7; i++) begin
            cyc();
            expect_lit(seq[i], i, i != 0, 1'b0, 1'b0);
        end

        // Divide by three, then hold with clock_sel=0.
        bus_if.clock_sel = CW'(3);
        for (int k = 1; k <= 9; k++) begin
            cyc();
            if (k == 8) expect_lit(21, 8, 1'b0, 1'b0, 1'b0);
            if (k == 9) expect_lit(34, 9, 1'b1, 1'b0, 1'b0);
        end
        bus_if.clock_sel = CW'(0);
        for (int k = 0; k < 20; k++) begin
            cyc();
            expect_lit(34, 9, 1'b0, 1'b0, 1'b0);
        end

        // Run to the last representable term and through the wrap.
        bus_if.clock_sel = CW'(1);
        repeat (35) cyc();
        expect_lit(701408733, 44, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_lit(0, 0, 1'b1, 1'b1, 1'b0);
        cyc();
        expect_lit(1, 1, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_lit(1, 2, 1'b1, 1'b0, 1'b0);
        cyc();
        expect_lit(2, 3, 1'b1, 1'b0, 1'b0);

        // Hold at 13, then resume at divide-by-two.
        repeat (4) cyc();
        expect_lit(13, 7, 1'b1, 1'b0, 1'b0);
        bus_if.switch = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            expect_lit(13, 7, 1'b0, 1'b0, 1'b0);
        end
        bus_if.switch    = 1'b1;
        bus_if.clock_sel = CW'(2);
        cyc();
        expect_lit(13, 7, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_lit(13, 7, 1'b0, 1'b0, 1'b0);
        cyc();
        expect_lit(21, 8, 1'b1, 1'b0, 1'b0);

        // Restart colliding with a due step.
        bus_if.clock_sel = CW'(1);
        bus_if.restart   = 1'b1;
        cyc();
        expect_lit(0, 0, 1'b0, 1'b0, 1'b0);
        bus_if.restart = 1'b0;
        for (int i = 1; i < 7; i++) begin
            cyc();
            expect_lit(seq[i], i, 1'b1, 1'b0, 1'b0);
        end
        bus_if.restart = 1'b1;
        cyc();
        expect_lit(0, 0, 1'b0, 1'b0, 1'b0);
        bus_if.restart = 1'b0;
        for (int i = 1; i < 4; i++) begin
            cyc();
            expect_lit(seq[i], i, 1'b1, 1'b0, 1'b0);
        end

        // Asynchronous reset between edges while the divider is part-way through.
        bus_if.clock_sel = CW'(5);
        cyc();
        cyc();
        expect_lit(2, 3, 1'b0, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b0;
        expect_lit(0, 0, 1'b0, 1'b0, 1'b1);
        cyc();
        expect_lit(0, 0, 1'b0, 1'b0, 1'b1);
        cyc();
        rst_n = 1'b1;
        bus_if.clock_sel = CW'(1);
        cyc();
        expect_lit(0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            cyc();
            expect_lit(seq[i], i, 1'b1, 1'b0, 1'b0);
        end

        // Random run/hold, rate changes and occasional restarts.
        for (int k = 0; k < 3000; k++) begin
            cyc();
            bus_if.switch  = ($urandom_range(7) != 0);
            bus_if.restart = ($urandom_range(499) == 0);
            if ($urandom_range(15) == 0) begin
                r = $urandom_range(9);
                if (r == 0)      bus_if.clock_sel = CW'(0);
                else if (r < 8)  bus_if.clock_sel = CW'(r / 2 + 1);
                else             bus_if.clock_sel = CW'($urandom_range(8, 63));
            end
        end
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
